pg_ctrl: RTL

PG_CTRL -- requirements
Module: pg_ctrl

---
 rtl/pg_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pg_ctrl.sv
`default_nettype none
// ============================================================================
// pg_ctrl : power-gating sequencer (isolate, save, switch off, restore, reset)
// Rev 1.0 : initial release
// ============================================================================
module pg_ctrl #(
    parameter int unsigned SAVE_CYC    = 2,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned RESTORE_CYC = 2,
    parameter int unsigned TMO         = 16
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       pwr_sw_ack,
    output logic       pwr_sw_en,
    output logic       iso_en,
    output logic       ret_save,
    output logic       ret_restore,
    output logic       pg_resetn,
    output logic [2:0] pg_state,
    output logic       pg_err
);

    typedef enum logic [2:0] {
        ST_ON       = 3'd0,
        ST_ISO      = 3'd1,
        ST_SAVE     = 3'd2,
        ST_PWR_DN   = 3'd3,
        ST_OFF      = 3'd4,
        ST_PWR_UP   = 3'd5,
        ST_RST_HOLD = 3'd6,
        ST_RESTORE  = 3'd7
    } state_t;

    // Dwell counter starts at 0 on entry, so "N cycles" ends when it reads N-1.
    localparam logic [7:0] c_save_last    = 8'(SAVE_CYC - 1);
    localparam logic [7:0] c_rst_last     = 8'(RST_HOLD - 1);
    localparam logic [7:0] c_restore_last = 8'(RESTORE_CYC - 1);
    localparam logic [7:0] c_tmo_last     = 8'(TMO - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_set_err;
    logic       w_tmo;

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_tmo     = (r_cnt == c_tmo_last);
        case (r_state)
            ST_ON:       if (sleep_req && !wake_req) w_next = ST_ISO;
            ST_ISO:      w_next = ST_SAVE;
            ST_SAVE:     if (r_cnt == c_save_last) w_next = ST_PWR_DN;
            ST_PWR_DN: begin
                // A genuine ack on the timeout cycle takes precedence over the error.
                if (!pwr_sw_ack) begin
                    w_next = ST_OFF;
                end else if (w_tmo) begin
                    w_next    = ST_OFF;
                    w_set_err = 1'b1;
                end
            end
            ST_OFF:      if (wake_req) w_next = ST_PWR_UP;
            ST_PWR_UP: begin
                if (pwr_sw_ack) begin
                    w_next = ST_RST_HOLD;
                end else if (w_tmo) begin
                    w_set_err = 1'b1;
                end
            end
            ST_RST_HOLD: if (r_cnt == c_rst_last) w_next = ST_RESTORE;
            ST_RESTORE:  if (r_cnt == c_restore_last) w_next = ST_ON;
            default:     w_next = ST_ON;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= ST_ON;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pwr_sw_en   = 1'b1;
        iso_en      = 1'b0;
        ret_save    = 1'b0;
        ret_restore = 1'b0;
        pg_resetn   = 1'b1;
        case (r_state)
            ST_ON:       ;
            ST_ISO:      iso_en = 1'b1;
            ST_SAVE: begin
                iso_en   = 1'b1;
                ret_save = 1'b1;
            end
            ST_PWR_DN, ST_OFF: begin
                pwr_sw_en = 1'b0;
                iso_en    = 1'b1;
                pg_resetn = 1'b0;
            end
            ST_PWR_UP, ST_RST_HOLD: begin
                iso_en    = 1'b1;
                pg_resetn = 1'b0;
            end
            ST_RESTORE: begin
                iso_en      = 1'b1;
                ret_restore = 1'b1;
            end
            default: ;
        endcase
    end

    assign pg_state = r_state;
    assign pg_err   = r_err;

endmodule
`default_nettype wire
